muldiv_iter: RTL

- Shared iterative multiply/divide unit for the EX stage. Generalises the single-mode, fixed-width divider into one engine that handles signed/unsigned MULT and DIV.
- Width and bits-retired-per-cycle are configurable; supports annul and divide-by-zero flagging.
- Results are delivered as {hi, lo} in MIPS convention, feeding the HI/LO write path.
- The EX stage drives start/annul and stalls the pipeline while busy_o is high.

---
 rtl/muldiv_iter_pkg.sv | 27 ++
 rtl/muldiv_iter_step.sv | 40 ++++
 rtl/muldiv_iter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op_i encodings, the FSM states and small op-decode helpers.
package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared engine: BPC chained shift-add (multiply)
// or restoring subtract-compare (divide) steps on the {hi, lo} accumulator.
module muldiv_iter_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_c_o,
    output logic [WIDTH-1:0] lo_c_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rr;
    logic           ge;

    // Multiply retires the multiplier LSB into lo; divide shifts the dividend MSB into the remainder.
    always_comb begin
        hi_c_o = hi_i;
        lo_c_o = lo_i;
        sum    = '0;
        rr     = '0;
        ge     = 1'b0;
        for (int i = 0; i < int'(BPC); i++) begin
            if (is_div_i) begin
                rr     = {hi_c_o, lo_c_o[WIDTH-1]};
                ge     = (rr >= {1'b0, b_i});
                hi_c_o = ge ? WIDTH'(rr - {1'b0, b_i}) : rr[WIDTH-1:0];
                lo_c_o = {lo_c_o[WIDTH-2:0], ge};
            end else begin
                sum    = {1'b0, hi_c_o} + ({(WIDTH+1){lo_c_o[0]}} & {1'b0, b_i});
                hi_c_o = sum[WIDTH:1];
                lo_c_o = {sum[0], lo_c_o[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned MULT/DIV engine for the EX stage.
// Operates on operand magnitudes and applies the sign fix in one extra cycle.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dz_o
);

    localparam int unsigned N     = WIDTH / BPC;
    localparam int unsigned CNT_W = $clog2(N + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    md_op_e             op;
    logic               signed_op, div_op, a_neg, b_neg, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;

    // Operand decode for the accept cycle.
    always_comb begin
        op        = md_op_e'(op_i);
        signed_op = op_is_signed(op);
        div_op    = op_is_div(op);
        a_neg     = signed_op & opa_i[WIDTH-1];
        b_neg     = signed_op & opb_i[WIDTH-1];
        a_mag     = a_neg ? -opa_i : opa_i;
        b_mag     = b_neg ? -opb_i : opb_i;
        accept    = start_i & ~annul_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    end

    muldiv_iter_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .b_i      (b_q),
        .hi_c_o   (step_hi),
        .lo_c_o   (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        prod     = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    is_div_d = div_op;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = div_op & a_neg;
                    acc_hi_d = '0;
                    acc_lo_d = div_op ? a_mag : b_mag;
                    b_d      = div_op ? b_mag : a_mag;
                    cnt_d    = '0;
                    // Divide by zero skips the engine and reports immediately.
                    if (div_op && (opb_i == '0)) begin
                        state_d = ST_DONE;
                        hi_d    = opa_i;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    prod = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
                    if (is_div_q) begin
                        lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                    dz_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_CALC) || (state_d == ST_FIX);
        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = ready_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign dz_o    = dz_q;

endmodule
